imem_boot_loader: RTL and testbench

Program-load front end that sits directly upstream of the single-cycle RV32I core top module. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions. It writes them into the instruction memory write port and holds the core in reset until a complete, checksum-verified program is in memory. On success it releases the core; on a malformed load it parks in an error state with the core held in reset.

---
 rtl/imem_boot_loader_if.sv | 31 +++
 rtl/imem_boot_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
// The loader takes the slave view. Whatever feeds bytes in and watches
// the memory writes takes the master view.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Program-load front end for the RV32I core.
// A byte frame arrives in this order: count low byte, count high byte,
// count*4 instruction bytes (LSB first), then one XOR checksum byte.
// Instructions are written to imem at addresses 0..count-1.
// The core is held in reset until the checksum matches.
// Any malformed frame parks the loader in ERR until reset.
module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  output logic                core_reset,
  output logic                load_done,
  output logic                load_error
);

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // The length check is done one bit wider, so a MAX_WORDS of 65536 still fits.
  localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

  state_t            state, state_n;
  logic [15:0]       count, count_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [15:0]       word_idx, word_idx_n;
  logic [23:0]       word_buf, word_buf_n;
  logic [7:0]        csum, csum_n;
  logic              byte_ready_q, byte_ready_n;
  logic              imem_we_q, imem_we_n;
  logic [ADDR_W-1:0] imem_waddr_q, imem_waddr_n;
  logic [31:0]       imem_wdata_q, imem_wdata_n;
  logic              core_reset_q, core_reset_n;
  logic              load_done_q, load_done_n;
  logic              load_error_q, load_error_n;

  logic              xfer;
  logic [15:0]       hdr_count;
  logic [15:0]       last_word;

  assign xfer      = bus.byte_valid && byte_ready_q;
  assign hdr_count = {bus.byte_data, count[7:0]};
  assign last_word = count - 16'd1;

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_waddr = imem_waddr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_reset     = core_reset_q;
  assign load_done      = load_done_q;
  assign load_error     = load_error_q;

  // Register all loader state; reset discards any partial frame at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_HDR0;
      count        <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      byte_idx     <= byte_idx_n;
      word_idx     <= word_idx_n;
      word_buf     <= word_buf_n;
      csum         <= csum_n;
      byte_ready_q <= byte_ready_n;
      imem_we_q    <= imem_we_n;
      imem_waddr_q <= imem_waddr_n;
      imem_wdata_q <= imem_wdata_n;
      core_reset_q <= core_reset_n;
      load_done_q  <= load_done_n;
      load_error_q <= load_error_n;
    end
  end

  // Frame parser: next state, word assembly, write strobe and the running checksum.
  always_comb begin
    state_n      = state;
    count_n      = count;
    byte_idx_n   = byte_idx;
    word_idx_n   = word_idx;
    word_buf_n   = word_buf;
    csum_n       = csum;
    imem_we_n    = 1'b0;
    imem_waddr_n = imem_waddr_q;
    imem_wdata_n = imem_wdata_q;
    core_reset_n = core_reset_q;
    load_done_n  = load_done_q;
    load_error_n = load_error_q;

    case (state)
      S_HDR0: begin
        if (xfer) begin
          count_n[7:0] = bus.byte_data;
          csum_n       = csum ^ bus.byte_data;
          state_n      = S_HDR1;
        end
      end

      S_HDR1: begin
        if (xfer) begin
          count_n = hdr_count;
          csum_n  = csum ^ bus.byte_data;
          if (hdr_count == 16'd0 || {1'b0, hdr_count} > MAX_COUNT) begin
            state_n      = S_ERR;
            load_error_n = 1'b1;
          end else begin
            state_n = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          csum_n     = csum ^ bus.byte_data;
          byte_idx_n = byte_idx + 2'd1;
          case (byte_idx)
            2'd0: word_buf_n[7:0]   = bus.byte_data;
            2'd1: word_buf_n[15:8]  = bus.byte_data;
            2'd2: word_buf_n[23:16] = bus.byte_data;
            default: begin
              imem_we_n    = 1'b1;
              imem_waddr_n = word_idx[ADDR_W-1:0];
              imem_wdata_n = {bus.byte_data, word_buf};
              word_idx_n   = word_idx + 16'd1;
              if (word_idx == last_word) begin
                state_n = S_CSUM;
              end
            end
          endcase
        end
      end

      S_CSUM: begin
        if (xfer) begin
          if (bus.byte_data == csum) begin
            state_n      = S_RUN;
            core_reset_n = 1'b0;
            load_done_n  = 1'b1;
          end else begin
            state_n      = S_ERR;
            load_error_n = 1'b1;
          end
        end
      end

      S_RUN: begin
        state_n = S_RUN;
      end

      S_ERR: begin
        state_n = S_ERR;
      end

      default: begin
        state_n = S_HDR0;
      end
    endcase

    byte_ready_n = (state_n != S_RUN) && (state_n != S_ERR);
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader.
// Expected instruction-memory writes are queued as frames are driven.
// A monitor pops them as imem_we pulses occur.
module tb_imem_boot_loader;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  logic core_reset;
  logic load_done;
  logic load_error;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W+31:0] expQ[$];
  logic [31:0]        words[$];
  logic               prevWe = 1'b0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare each write strobe against the scoreboard, and reject back-to-back strobes.
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prevWe = 1'b0;
    end else begin
      if (bus.imem_we === 1'b1) begin
        checkEq("we_not_consecutive", 32'(prevWe), 32'd0);
        checkEq("write_expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          logic [ADDR_W+31:0] e;
          e = expQ.pop_front();
          checkEq("write_addr", 32'(bus.imem_waddr), 32'(e[ADDR_W+31:32]));
          checkEq("write_data", bus.imem_wdata, e[31:0]);
        end
      end
      prevWe = bus.imem_we;
    end
  end

  // Give up on a hung design.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    int waitCnt = 0;
    while (bus.byte_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 50) begin
      checkEq("byte_ready_timeout", 32'(bus.byte_ready), 32'd1);
    end else begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      @(negedge clk);
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] count, input int gap, input logic badCsum);
    logic [7:0]  x;
    logic [31:0] cur;
    logic [7:0]  b;
    x = 8'h00;
    sendByte(count[7:0], gap);
    x ^= count[7:0];
    sendByte(count[15:8], gap);
    x ^= count[15:8];
    if (count != 16'd0 && count <= 16'd256) begin
      for (int w = 0; w < int'(count); w++) begin
        cur = words[w];
        for (int k = 0; k < 4; k++) begin
          b = cur[8*k +: 8];
          if (k == 3) expQ.push_back({ADDR_W'(w), cur});
          sendByte(b, gap);
          x ^= b;
        end
      end
      sendByte(badCsum ? (x ^ 8'h07) : x, gap);
    end
  endtask

  task automatic checkOutput(input logic expDone, input logic expErr);
    checkEq("core_reset", 32'(core_reset), 32'(!expDone));
    checkEq("load_done", 32'(load_done), 32'(expDone));
    checkEq("load_error", 32'(load_error), 32'(expErr));
    checkEq("byte_ready_low", 32'(bus.byte_ready), 32'd0);
    checkEq("pending_writes", 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset();
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkEq("ready_after_reset", 32'(bus.byte_ready), 32'd1);
  endtask

  task automatic loadTwoWords();
    words.delete();
    words.push_back(32'h00500093);
    words.push_back(32'h00A00113);
  endtask

  initial begin
    logic [7:0] partial[6];
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clk);

    checkEq("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    checkEq("rst_imem_we", 32'(bus.imem_we), 32'd0);
    checkEq("rst_waddr", 32'(bus.imem_waddr), 32'd0);
    checkEq("rst_wdata", bus.imem_wdata, 32'd0);
    checkEq("rst_core_reset", 32'(core_reset), 32'd1);
    checkEq("rst_load_done", 32'(load_done), 32'd0);
    checkEq("rst_load_error", 32'(load_error), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkEq("ready_after_reset", 32'(bus.byte_ready), 32'd1);

    $display("[TB] two-word back-to-back load");
    loadTwoWords();
    applyStimulus(16'd2, 0, 1'b0);
    checkOutput(1'b1, 1'b0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    repeat (3) @(negedge clk);
    bus.byte_valid = 1'b0;
    checkOutput(1'b1, 1'b0);

    $display("[TB] bad checksum");
    doReset();
    applyStimulus(16'd2, 0, 1'b1);
    checkOutput(1'b0, 1'b1);

    $display("[TB] zero-length header");
    doReset();
    applyStimulus(16'd0, 0, 1'b0);
    checkOutput(1'b0, 1'b1);

    $display("[TB] 256-word load");
    doReset();
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back($urandom);
    applyStimulus(16'd256, 0, 1'b0);
    checkOutput(1'b1, 1'b0);
    checkEq("last_waddr", 32'(bus.imem_waddr), 32'hFF);
    checkEq("last_wdata", bus.imem_wdata, words[255]);

    $display("[TB] 257-word header");
    doReset();
    applyStimulus(16'h0101, 0, 1'b0);
    checkOutput(1'b0, 1'b1);

    $display("[TB] two-word load with gaps");
    doReset();
    loadTwoWords();
    applyStimulus(16'd2, 3, 1'b0);
    checkOutput(1'b1, 1'b0);

    $display("[TB] reset mid-frame");
    doReset();
    partial[0] = 8'h02; partial[1] = 8'h00; partial[2] = 8'h93;
    partial[3] = 8'h00; partial[4] = 8'h50; partial[5] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) expQ.push_back({ADDR_W'(0), 32'h00500093});
      sendByte(partial[i], 0);
    end
    #2;
    reset = 1'b1;
    #1;
    checkEq("abort_byte_ready", 32'(bus.byte_ready), 32'd0);
    checkEq("abort_imem_we", 32'(bus.imem_we), 32'd0);
    checkEq("abort_waddr", 32'(bus.imem_waddr), 32'd0);
    checkEq("abort_wdata", bus.imem_wdata, 32'd0);
    checkEq("abort_core_reset", 32'(core_reset), 32'd1);
    checkEq("abort_load_done", 32'(load_done), 32'd0);
    checkEq("abort_load_error", 32'(load_error), 32'd0);
    checkEq("abort_pending", 32'(expQ.size()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkEq("ready_after_abort", 32'(bus.byte_ready), 32'd1);
    loadTwoWords();
    applyStimulus(16'd2, 0, 1'b0);
    checkOutput(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
